// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round sequencer: debounces the player's punch, samples
// a free-running LFSR for the cpu move, judges the round, holds the result
// for a display window and keeps a first-to-WIN_SCORE match score.
module rps_round_ctrl #(
  parameter int DEB_TICKS  = 4,
  parameter int SHOW_TICKS = 8,
  parameter int WIN_SCORE  = 3
) (
  input  logic       CLK,
  input  logic       Clear,
  input  logic       tick,
  input  logic [3:0] punch,
  input  logic       new_game,
  output logic [1:0] player_move,
  output logic [1:0] cpu_move,
  output logic [1:0] result,
  output logic [3:0] score_p,
  output logic [3:0] score_c,
  output logic       show,
  output logic       game_over,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE = 3'd0, READY = 3'd1, LOCK = 3'd2, SHOW = 3'd3, OVER = 3'd4} state_t;

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int SW = $clog2(SHOW_TICKS + 1);

  state_t        st_q, st_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [SW-1:0] shw_q, shw_d;
  logic [3:0]    cand_q, cand_d;
  logic [7:0]    lfsr_q;
  logic [1:0]    pm_d, cm_d, res_d;
  logic [3:0]    sp_d, sc_d;
  logic [1:0]    pcode, cpu_pick;
  logic          valid, pwin;

  assign state = st_q;

  // Free-running LFSR, the only source of cpu randomness.
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) lfsr_q <= 8'h01;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Button decode; anything that is not a single legal button is invalid.
  always_comb begin
    pcode = 2'b11;
    case (punch)
      4'b0001: pcode = 2'b00;
      4'b0010: pcode = 2'b01;
      4'b0100: pcode = 2'b10;
      default: pcode = 2'b11;
    endcase
  end
  assign valid    = (pcode != 2'b11);
  assign cpu_pick = (lfsr_q[1:0] == 2'b11) ? 2'b00 : lfsr_q[1:0];
  assign pwin     = (player_move == 2'b01 && cpu_pick == 2'b00) ||
                    (player_move == 2'b10 && cpu_pick == 2'b01) ||
                    (player_move == 2'b00 && cpu_pick == 2'b10);

  // Next-state and datapath updates for the round FSM.
  always_comb begin
    st_d   = st_q;
    deb_d  = deb_q;
    shw_d  = shw_q;
    cand_d = cand_q;
    pm_d   = player_move;
    cm_d   = cpu_move;
    res_d  = result;
    sp_d   = score_p;
    sc_d   = score_c;
    case (st_q)
      IDLE: if (punch == 4'b0000) begin
        st_d   = READY;
        pm_d   = 2'b11;
        cm_d   = 2'b11;
        res_d  = 2'b00;
        deb_d  = '0;
        cand_d = punch;
      end
      READY: begin
        // A changed or illegal punch restarts debounce, even on a tick.
        if (punch != cand_q || !valid) begin
          cand_d = punch;
          deb_d  = '0;
        end else if (tick) begin
          if (deb_q == DW'(DEB_TICKS - 1)) begin
            pm_d  = pcode;
            deb_d = '0;
            st_d  = LOCK;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
      end
      LOCK: begin
        cm_d  = cpu_pick;
        shw_d = '0;
        st_d  = SHOW;
        if (player_move == cpu_pick) begin
          res_d = 2'b11;
        end else if (pwin) begin
          res_d = 2'b01;
          if (score_p < 4'(WIN_SCORE)) sp_d = score_p + 4'd1;
        end else begin
          res_d = 2'b10;
          if (score_c < 4'(WIN_SCORE)) sc_d = score_c + 4'd1;
        end
      end
      SHOW: if (tick) begin
        if (shw_q == SW'(SHOW_TICKS - 1)) begin
          shw_d = '0;
          st_d  = (score_p == 4'(WIN_SCORE) || score_c == 4'(WIN_SCORE)) ? OVER : IDLE;
        end else begin
          shw_d = shw_q + 1'b1;
        end
      end
      OVER: if (new_game) begin
        sp_d = 4'd0;
        sc_d = 4'd0;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // State and output registers; show/game_over registered from next state.
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      st_q        <= IDLE;
      deb_q       <= '0;
      shw_q       <= '0;
      cand_q      <= 4'd0;
      player_move <= 2'b11;
      cpu_move    <= 2'b11;
      result      <= 2'b00;
      score_p     <= 4'd0;
      score_c     <= 4'd0;
      show        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      st_q        <= st_d;
      deb_q       <= deb_d;
      shw_q       <= shw_d;
      cand_q      <= cand_d;
      player_move <= pm_d;
      cpu_move    <= cm_d;
      result      <= res_d;
      score_p     <= sp_d;
      score_c     <= sc_d;
      show        <= (st_d == SHOW);
      game_over   <= (st_d == OVER);
    end
  end
endmodule

// File: tb/tb_rps_round_ctrl.sv
// Directed bench for rps_round_ctrl: table-driven debounce round, then
// hand-written sequences for clear, held button, match win and tie.
module tb_rps_round_ctrl;
  logic       CLK = 1'b0, Clear = 1'b1, tick = 1'b0, new_game = 1'b0;
  logic [3:0] punch = 4'd0;
  logic [1:0] player_move, cpu_move, result;
  logic [3:0] score_p, score_c;
  logic       show, game_over;
  logic [2:0] state;

  int n_cmp = 0, n_err = 0;
  int exp_sp = 0, exp_sc = 0;
  logic [7:0] m_lfsr, lock_l;

  rps_round_ctrl #(.DEB_TICKS(4), .SHOW_TICKS(8), .WIN_SCORE(3)) dut (
    .CLK(CLK), .Clear(Clear), .tick(tick), .punch(punch), .new_game(new_game),
    .player_move(player_move), .cpu_move(cpu_move), .result(result),
    .score_p(score_p), .score_c(score_c), .show(show), .game_over(game_over),
    .state(state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] nxt(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Reference LFSR, advancing on the same edges as the design's.
  always @(posedge CLK or posedge Clear)
    if (Clear) m_lfsr <= 8'h01;
    else       m_lfsr <= nxt(m_lfsr);

  function automatic logic [1:0] pick(input logic [7:0] l);
    int v;
    v = l[1:0];
    return 2'(v % 3);
  endfunction

  // Moves as 0,1,2: player wins when (p - c) mod 3 == 1.
  function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] c);
    int d;
    if (p == c) return 2'b11;
    d = (int'(p) - int'(c) + 3) % 3;
    return (d == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic score_update(input logic [1:0] r);
    if (r == 2'b01 && exp_sp < 3) exp_sp++;
    if (r == 2'b10 && exp_sc < 3) exp_sc++;
  endtask

  // Play one round with punch p, releasing the last debounce tick only when
  // the LFSR value of the LOCK cycle will produce cpu move `want`.
  task automatic play_round(input logic [3:0] p, input logic [1:0] pc, input logic [1:0] want);
    logic [1:0] r;
    int found;
    punch = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (state == 3'd1) break;
      @(negedge CLK);
    end
    check("ready_wait", state, 1);
    punch = p;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; @(negedge CLK);
      tick = 1'b0; @(negedge CLK);
    end
    check("still_ready", state, 1);
    found = 0;
    for (int k = 0; k < 400; k++) begin
      if (pick(nxt(m_lfsr)) == want) begin
        tick = 1'b1; @(negedge CLK);
        tick = 1'b0;
        found = 1;
        break;
      end
      @(negedge CLK);
    end
    check("cpu_timing", found, 1);
    check("lock_state", state, 2);
    check("lock_pm", player_move, pc);
    lock_l = m_lfsr;
    @(negedge CLK);
    r = judge(pc, pick(lock_l));
    score_update(r);
    check("show_state", state, 3);
    check("show_flag", show, 1);
    check("cpu_move", cpu_move, pick(lock_l));
    check("result", result, r);
    check("score_p", score_p, exp_sp);
    check("score_c", score_c, exp_sc);
  endtask

  // Tick through SHOW, counting ticks until it leaves.
  task automatic show_window(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (state != 3'd3) break;
      tick = 1'b1; @(negedge CLK);
      tick = 1'b0; n++;
      @(negedge CLK);
    end
  endtask

  typedef struct {
    logic [3:0] punch;
    logic       tick;
    logic [2:0] st;
    logic [1:0] pm;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [1:0] r;
    tbl[0]  = '{4'b0000, 1'b0, 3'd1, 2'b11};
    tbl[1]  = '{4'b0010, 1'b0, 3'd1, 2'b11};
    tbl[2]  = '{4'b0010, 1'b1, 3'd1, 2'b11};
    tbl[3]  = '{4'b0010, 1'b0, 3'd1, 2'b11};
    tbl[4]  = '{4'b0110, 1'b1, 3'd1, 2'b11};
    tbl[5]  = '{4'b0010, 1'b1, 3'd1, 2'b11};
    tbl[6]  = '{4'b0010, 1'b1, 3'd1, 2'b11};
    tbl[7]  = '{4'b0010, 1'b1, 3'd1, 2'b11};
    tbl[8]  = '{4'b0010, 1'b1, 3'd1, 2'b11};
    tbl[9]  = '{4'b0010, 1'b1, 3'd2, 2'b01};
    tbl[10] = '{4'b0010, 1'b0, 3'd3, 2'b01};

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_state", state, 0);
    check("rst_pm", player_move, 3);
    check("rst_cm", cpu_move, 3);
    check("rst_result", result, 0);
    check("rst_score_p", score_p, 0);
    check("rst_score_c", score_c, 0);
    check("rst_show", show, 0);
    check("rst_over", game_over, 0);

    // Debounce round with glitch and simultaneous change+tick
    Clear = 1'b0;
    for (int i = 0; i < 11; i++) begin
      punch = tbl[i].punch;
      tick  = tbl[i].tick;
      @(negedge CLK);
      check($sformatf("tbl_state[%0d]", i), state, tbl[i].st);
      check($sformatf("tbl_pm[%0d]", i), player_move, tbl[i].pm);
      if (tbl[i].st == 3'd2) lock_l = m_lfsr;
    end
    tick = 1'b0;
    r = judge(2'b01, pick(lock_l));
    score_update(r);
    check("r1_cpu", cpu_move, pick(lock_l));
    check("r1_result", result, r);
    check("r1_score_p", score_p, exp_sp);
    check("r1_score_c", score_c, exp_sc);
    check("r1_show", show, 1);

    // Clear in the middle of SHOW
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1; @(negedge CLK);
      tick = 1'b0; @(negedge CLK);
    end
    check("mid_show", state, 3);
    Clear = 1'b1;
    @(negedge CLK);
    exp_sp = 0; exp_sc = 0;
    check("clr_state", state, 0);
    check("clr_score_p", score_p, 0);
    check("clr_score_c", score_c, 0);
    check("clr_pm", player_move, 3);
    check("clr_cm", cpu_move, 3);
    check("clr_result", result, 0);
    check("clr_show", show, 0);

    // Button still held after clear: no new round
    Clear = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick = (i % 2 == 0);
      @(negedge CLK);
    end
    tick = 1'b0;
    check("held_state", state, 0);
    check("held_pm", player_move, 3);

    // Three forced player wins: stone vs scissors
    for (int rnd = 1; rnd <= 3; rnd++) begin
      play_round(4'b0010, 2'b01, 2'b00);
      check($sformatf("win%0d_score_p", rnd), score_p, rnd);
      show_window(n);
      check($sformatf("win%0d_ticks", rnd), n, 8);
      check($sformatf("win%0d_next", rnd), state, (rnd == 3) ? 4 : 0);
      if (rnd < 3) check($sformatf("win%0d_persist", rnd), result, 1);
    end
    check("over_flag", game_over, 1);

    // OVER ignores punch and tick; new_game restarts the match
    punch = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick = (i % 2 == 0);
      @(negedge CLK);
    end
    tick = 1'b0;
    check("over_hold", state, 4);
    check("over_score_p", score_p, 3);
    new_game = 1'b1;
    @(negedge CLK);
    new_game = 1'b0;
    exp_sp = 0; exp_sc = 0;
    check("ng_state", state, 0);
    check("ng_score_p", score_p, 0);
    check("ng_score_c", score_c, 0);
    check("ng_over", game_over, 0);

    // Tie round: paper vs paper
    play_round(4'b0100, 2'b10, 2'b10);
    check("tie_result", result, 3);
    show_window(n);
    check("tie_ticks", n, 8);
    check("tie_next", state, 0);
    check("tie_show_off", show, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rps_round_ctrl.md
Name: rps_round_ctrl

Overview:
Round sequencer for the rock-paper-scissors game. It debounces the player's punch and samples a free-running 8-bit LFSR to pick the computer's move. It then judges the round, holds the result for a display window and keeps a first-to-WIN_SCORE match score. Its outputs drive the LED-matrix colour decode, the 7-segment move decode and the score display. It runs on the fast system clock and uses a single-cycle `tick` enable from the clock divider for all timed waits.

Parameters:
DEB_TICKS, 4, consecutive ticks a punch must stay stable before it is accepted (minimum 1)
SHOW_TICKS, 8, ticks the round result is held before the next round (minimum 1)
WIN_SCORE, 3, points that end the match (1..15)

Ports:
CLK  input  1  system clock, rising edge
Clear  input  1  asynchronous reset, active-high
tick  input  1  one-CLK-cycle enable pulse from the clock divider
punch  input  4  player buttons; 0001 scissors, 0010 stone, 0100 paper
new_game  input  1  level; acts only in OVER, where it starts a new match
player_move  output  2  00 scissors, 01 stone, 10 paper, 11 none
cpu_move  output  2  same encoding as player_move
result  output  2  00 none, 01 player wins, 10 cpu wins, 11 tie
score_p  output  4  player score
score_c  output  4  cpu score
show  output  1  high while in SHOW
game_over  output  1  high while in OVER
state  output  3  IDLE=0, READY=1, LOCK=2, SHOW=3, OVER=4

Behaviour:
- Reset (Clear high, asynchronous):
  - state=IDLE, player_move=11, cpu_move=11, result=00.
  - score_p=0, score_c=0, show=0, game_over=0.
  - LFSR=8'h01, debounce and show counters=0.
- LFSR:
  - Advances every CLK cycle, including during reset release, in all states.
  - Next value = {l[6:0], l[7]^l[5]^l[4]^l[3]}. It never reaches 0.
- IDLE:
  - Waits for punch==0000. This forces a button release between rounds.
  - When punch==0000 is seen: go to READY, clear player_move/cpu_move to 11, result to 00, debounce count to 0.
- READY:
  - A candidate is valid only if punch is exactly one of 0001, 0010, 0100.
  - Any change of punch, or any invalid value (0, multi-bit, bit3 set), reloads the candidate and zeroes the debounce count.
  - On a tick with a valid, unchanged candidate, the count increments.
  - When the count reaches DEB_TICKS, latch player_move and go to LOCK.
- LOCK (exactly one cycle):
  - cpu_move <= LFSR[1:0] mod 3, using the LFSR value of this cycle (a raw value of 3 maps to 00).
  - result: equal moves give 11.
  - result: (player,cpu) = (stone,scissors), (paper,stone) or (scissors,paper) gives 01; any other pair gives 10.
- LOCK→SHOW edge:
  - A win increments score_p or score_c; a tie changes neither.
  - Scores saturate at WIN_SCORE.
- SHOW:
  - show=1; the show counter counts ticks.
  - After SHOW_TICKS ticks: go to OVER if either score == WIN_SCORE, else go to IDLE.
  - Moves and result persist until the next IDLE→READY transition.
- OVER:
  - game_over=1; punch is ignored.
  - new_game high: clear both scores, go to IDLE.
- new_game outside OVER is ignored. The tick input is ignored in IDLE, LOCK and OVER.
- Simultaneous cases:
  - A punch change on the same cycle as a tick resets the count; no increment.
  - Clear overrides everything at any point, including mid-SHOW and mid-debounce.
- All outputs are registered. Latency from the accepting tick to valid result is 2 CLK cycles.

Test Plan:
- Clear pulse mid-SHOW -> next cycle: state=0, scores 0, moves 11, result 00, show=0; LFSR restarts at 0x01.
- punch=0000, then 0010 held with tick every 4 cycles (DEB_TICKS=4) -> LOCK exactly on the cycle after the 4th tick. player_move=01; cpu_move matches the bench LFSR model (0x01 → 0x02 → 0x04 → 0x08 → 0x11 …) mod 3; result matches the judging table.
- punch glitches 0010→0110→0010 during debounce -> count restarts; acceptance needs 4 further ticks.
- Forced sequence of three player wins (bench times the punch so that LFSR[1:0] gives scissors, player plays stone) -> score_p 1, 2, 3; after the 3rd SHOW window, state=4, game_over=1; new_game -> scores 0, state=0.
- Player holds the button after a round -> stays in IDLE, no new round until punch=0000.
- Tie round -> result=11, both scores unchanged; show high for exactly 8 ticks.
